// File: rtl/dfr_matrix_multiply.sv
// rtl/dfr_matrix_multiply.sv - output-layer Y = X * W multiply engine with registered memory-port outputs
module dfr_matrix_multiply #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int X_ROWS        = 5,
  parameter int Y_COLS        = 5,
  parameter int X_COLS_Y_ROWS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_we
);

  typedef enum logic [1:0] {IDLE, FETCH, MAC, WRITE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(X_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(Y_COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(X_COLS_Y_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] K_N      = ADDR_WIDTH'(X_COLS_Y_ROWS);
  localparam logic [ADDR_WIDTH-1:0] C_N      = ADDR_WIDTH'(Y_COLS);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  state_t                    state, state_d;
  logic [ADDR_WIDTH-1:0]     i, j, k, i_d, j_d, k_d;
  logic [ADDR_WIDTH-1:0]     x_addr_d, w_addr_d, y_addr_d;
  logic [2*DATA_WIDTH-1:0]   acc, acc_d, prod, acc_sum;
  logic [DATA_WIDTH-1:0]     y_data_d;
  logic                      busy_d, done_d, y_we_d;
  logic                      last_elem;

  // Full-width product and wrapping accumulation; read data arrives in MAC for the FETCH address.
  assign prod      = (2*DATA_WIDTH)'(x_data) * (2*DATA_WIDTH)'(w_data);
  assign acc_sum   = acc + prod;
  assign last_elem = (i == ROW_LAST) && (j == COL_LAST);

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d  = state;
    i_d      = i;
    j_d      = j;
    k_d      = k;
    acc_d    = acc;
    x_addr_d = x_addr;
    w_addr_d = w_addr;
    y_addr_d = y_addr;
    y_data_d = y_data;
    busy_d   = busy;
    done_d   = 1'b0;
    y_we_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          busy_d   = 1'b1;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          acc_d    = '0;
          x_addr_d = '0;
          w_addr_d = '0;
        end
      end
      FETCH: state_d = MAC;
      MAC: begin
        acc_d = acc_sum;
        if (k != K_LAST) begin
          k_d      = k + ONE;
          x_addr_d = i * K_N + k + ONE;
          w_addr_d = (k + ONE) * C_N + j;
          state_d  = FETCH;
        end else begin
          // The write strobe and data are registered here so they appear during WRITE.
          state_d  = WRITE;
          y_we_d   = 1'b1;
          y_addr_d = i * C_N + j;
          y_data_d = acc_sum[DATA_WIDTH-1:0];
          done_d   = last_elem;
        end
      end
      WRITE: begin
        acc_d = '0;
        k_d   = '0;
        if (j == COL_LAST) begin
          j_d = '0;
          i_d = (i == ROW_LAST) ? '0 : i + ONE;
        end else begin
          j_d = j + ONE;
        end
        if (last_elem) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d  = FETCH;
          x_addr_d = i_d * K_N;
          w_addr_d = j_d;
        end
      end
      default: state_d = IDLE;
    endcase
    // Soft reset wins over everything, including a same-cycle start.
    if (clr) begin
      state_d  = IDLE;
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      acc_d    = '0;
      x_addr_d = '0;
      w_addr_d = '0;
      y_addr_d = '0;
      y_data_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      y_we_d   = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      acc    <= '0;
      x_addr <= '0;
      w_addr <= '0;
      y_addr <= '0;
      y_data <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y_we   <= 1'b0;
    end else begin
      state  <= state_d;
      i      <= i_d;
      j      <= j_d;
      k      <= k_d;
      acc    <= acc_d;
      x_addr <= x_addr_d;
      w_addr <= w_addr_d;
      y_addr <= y_addr_d;
      y_data <= y_data_d;
      busy   <= busy_d;
      done   <= done_d;
      y_we   <= y_we_d;
    end
  end

endmodule

// File: tb/tb_dfr_matrix_multiply.sv
// tb/tb_dfr_matrix_multiply.sv - self-checking bench for dfr_matrix_multiply
module tb_dfr_matrix_multiply;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 2x2x2, 32-bit data
  logic a_start, a_clr, a_busy, a_done, a_we;
  logic [31:0] a_xa, a_wa, a_ya, a_xd, a_wd, a_yd;
  // Instance B: 1x1x2, 8-bit data
  logic b_start, b_clr, b_busy, b_done, b_we;
  logic [31:0] b_xa, b_wa, b_ya;
  logic [7:0]  b_xd, b_wd, b_yd;
  // Instance C: default 5x5x5
  logic c_start, c_clr, c_busy, c_done, c_we;
  logic [31:0] c_xa, c_wa, c_ya, c_xd, c_wd, c_yd;

  logic [31:0] ax [32], aw [32], bx [32], bw [32], cx [32], cw [32];
  logic [31:0] exp_y [32];

  typedef struct {int inst; int addr; logic [31:0] data; logic done;} wr_t;
  wr_t log_q [$];
  int  bc [3];
  int  stray = 0;
  int  tests = 0;
  int  failed = 0;

  dfr_matrix_multiply #(.X_ROWS(2), .Y_COLS(2), .X_COLS_Y_ROWS(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .clr(a_clr), .busy(a_busy), .done(a_done),
    .x_addr(a_xa), .x_data(a_xd), .w_addr(a_wa), .w_data(a_wd),
    .y_addr(a_ya), .y_data(a_yd), .y_we(a_we));

  dfr_matrix_multiply #(.DATA_WIDTH(8), .X_ROWS(1), .Y_COLS(1), .X_COLS_Y_ROWS(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .clr(b_clr), .busy(b_busy), .done(b_done),
    .x_addr(b_xa), .x_data(b_xd), .w_addr(b_wa), .w_data(b_wd),
    .y_addr(b_ya), .y_data(b_yd), .y_we(b_we));

  dfr_matrix_multiply u_c (
    .clk(clk), .rst(rst), .start(c_start), .clr(c_clr), .busy(c_busy), .done(c_done),
    .x_addr(c_xa), .x_data(c_xd), .w_addr(c_wa), .w_data(c_wd),
    .y_addr(c_ya), .y_data(c_yd), .y_we(c_we));

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    a_xd <= ax[a_xa[4:0]];
    a_wd <= aw[a_wa[4:0]];
    b_xd <= bx[b_xa[4:0]][7:0];
    b_wd <= bw[b_wa[4:0]][7:0];
    c_xd <= cx[c_xa[4:0]];
    c_wd <= cw[c_wa[4:0]];
  end

  // Write/busy monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (a_we) log_q.push_back('{0, int'(a_ya), a_yd, a_done});
    if (b_we) log_q.push_back('{1, int'(b_ya), {24'd0, b_yd}, b_done});
    if (c_we) log_q.push_back('{2, int'(c_ya), c_yd, c_done});
    if (a_busy) bc[0]++;
    if (b_busy) bc[1]++;
    if (c_busy) bc[2]++;
    if ((a_done && !a_we) || (b_done && !b_we) || (c_done && !c_we)) stray++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Plain matrix product reference, truncated to the data width.
  function automatic void mm(input logic [31:0] x [32], input logic [31:0] w [32],
                             input int rows, input int cols, input int kk, input int dw);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        logic [63:0] s;
        s = 64'd0;
        for (int t = 0; t < kk; t++) s += 64'(x[r*kk+t]) * 64'(w[t*cols+c]);
        if (dw < 32) s &= (64'd1 << dw) - 64'd1;
        exp_y[r*cols+c] = s[31:0];
      end
  endfunction

  function automatic logic busy_of(input int inst);
    case (inst)
      0: return a_busy;
      1: return b_busy;
      default: return c_busy;
    endcase
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: a_start = v;
      1: b_start = v;
      default: c_start = v;
    endcase
  endtask

  function automatic int wcount(input int inst, input int lb);
    int m = 0;
    for (int e = lb; e < log_q.size(); e++) if (log_q[e].inst == inst) m++;
    return m;
  endfunction

  task automatic wait_idle(input int inst, input string tag);
    for (int c = 0; c < 400 && busy_of(inst); c++) @(negedge clk);
    chk({tag, "_idle_timeout"}, 64'(busy_of(inst)), 64'd0);
  endtask

  task automatic check_log(input int inst, input string tag, input int lb, input int bb,
                           input int n, input int exp_busy);
    int m = 0;
    for (int e = lb; e < log_q.size(); e++) begin
      if (log_q[e].inst == inst) begin
        if (m < n) begin
          chk($sformatf("%s_addr%0d", tag, m), 64'(log_q[e].addr), 64'(m));
          chk($sformatf("%s_data%0d", tag, m), 64'(log_q[e].data), 64'(exp_y[m]));
          chk($sformatf("%s_done%0d", tag, m), 64'(log_q[e].done), 64'(m == n - 1));
        end
        m++;
      end
    end
    chk({tag, "_writes"}, 64'(m), 64'(n));
    chk({tag, "_busy_cycles"}, 64'(bc[inst] - bb), 64'(exp_busy));
  endtask

  task automatic run(input int inst, input string tag, input int n, input int exp_busy,
                     input bit restart);
    int lb, bb;
    lb = log_q.size();
    bb = bc[inst];
    @(negedge clk) set_start(inst, 1'b1);
    @(negedge clk) set_start(inst, 1'b0);
    chk({tag, "_busy_after_start"}, 64'(busy_of(inst)), 64'd1);
    if (restart) begin
      repeat (2) @(negedge clk);
      set_start(inst, 1'b1);
      @(negedge clk) set_start(inst, 1'b0);
    end
    wait_idle(inst, tag);
    check_log(inst, tag, lb, bb, n, exp_busy);
  endtask

  initial begin
    int lb, seen;
    rst = 1'b0;
    a_start = 0; b_start = 0; c_start = 0;
    a_clr = 0; b_clr = 0; c_clr = 0;
    for (int e = 0; e < 32; e++) begin
      ax[e] = 0; aw[e] = 0; bx[e] = 0; bw[e] = 0; cx[e] = 0; cw[e] = 0; exp_y[e] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_we", 64'(a_we), 64'd0);
    chk("rst_addrs", {a_xa, a_wa} | {a_ya, a_yd}, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed 2x2x2
    ax[0] = 1; ax[1] = 2; ax[2] = 3; ax[3] = 4;
    aw[0] = 5; aw[1] = 6; aw[2] = 7; aw[3] = 8;
    exp_y[0] = 19; exp_y[1] = 22; exp_y[2] = 43; exp_y[3] = 50;
    run(0, "a_dir", 4, 20, 1'b0);

    // Start pulsed again 3 cycles in is ignored
    run(0, "a_restart", 4, 20, 1'b1);

    // Random 2x2x2 data
    for (int e = 0; e < 4; e++) begin ax[e] = $urandom; aw[e] = $urandom; end
    mm(ax, aw, 2, 2, 2, 32);
    run(0, "a_rand", 4, 20, 1'b0);

    // Soft clear in the middle of element 2
    lb = log_q.size();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && seen < 2; c++) begin
      @(negedge clk);
      if (a_we) seen++;
    end
    chk("clr_reach_elem2", 64'(seen), 64'd2);
    repeat (2) @(negedge clk);
    a_clr = 1'b1;
    @(negedge clk) a_clr = 1'b0;
    chk("clr_busy", 64'(a_busy), 64'd0);
    chk("clr_we", 64'(a_we), 64'd0);
    repeat (12) @(negedge clk);
    chk("clr_no_more_writes", 64'(wcount(0, lb)), 64'd2);
    for (int e = 0; e < 4; e++) begin ax[e] = $urandom; aw[e] = $urandom; end
    mm(ax, aw, 2, 2, 2, 32);
    run(0, "a_after_clr", 4, 20, 1'b0);

    // Asynchronous reset during a write cycle
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !a_we; c++) @(negedge clk);
    chk("arst_saw_write", 64'(a_we), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(a_busy), 64'd0);
    chk("arst_we", 64'(a_we), 64'd0);
    chk("arst_done", 64'(a_done), 64'd0);
    lb = log_q.size();
    @(negedge clk) rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_stays_idle", 64'(a_busy), 64'd0);
    chk("arst_no_writes", 64'(wcount(0, lb)), 64'd0);
    for (int e = 0; e < 4; e++) begin ax[e] = $urandom; aw[e] = $urandom; end
    mm(ax, aw, 2, 2, 2, 32);
    run(0, "a_after_arst", 4, 20, 1'b0);

    // 8-bit truncation, 1x1x2
    bx[0] = 255; bx[1] = 255; bw[0] = 255; bw[1] = 255;
    exp_y[0] = 32'h02;
    run(1, "b_trunc", 1, 5, 1'b0);
    for (int e = 0; e < 2; e++) begin bx[e] = $urandom_range(0, 255); bw[e] = $urandom_range(0, 255); end
    mm(bx, bw, 1, 1, 2, 8);
    run(1, "b_rand", 1, 5, 1'b0);

    // Default 5x5x5
    for (int e = 0; e < 25; e++) begin cx[e] = 1; cw[e] = 2; exp_y[e] = 10; end
    run(2, "c_const", 25, 275, 1'b0);
    for (int e = 0; e < 25; e++) begin cx[e] = $urandom; cw[e] = $urandom; end
    mm(cx, cw, 5, 5, 5, 32);
    run(2, "c_rand", 25, 275, 1'b0);

    chk("stray_done", 64'(stray), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
